game_ram_arbiter: RTL and testbench

//  Time-multiplexes the single-port game-table RAM (ROWS x COLS bits, 1-cycle sync read) between
//  the display row scanner (internal, continuous) and the game controller (req/gnt port).

---
 rtl/tetris_pkg.sv | 17 +
 rtl/tetris_scan_counter.sv | 22 ++
 rtl/game_ram_arbiter.sv | 139 +++++++++++++
 tb/tb_game_ram_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared constants and arbiter state encoding for the game-table RAM path.
package tetris_pkg;

  localparam int ROWS       = 10;
  localparam int COLS       = 10;
  localparam int AW         = 4;
  localparam int MAX_STARVE = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_RD  = 3'd1,
    D_CAP = 3'd2,
    G_ACC = 3'd3,
    G_CAP = 3'd4
  } arb_state_e;

endpackage

// File: rtl/tetris_scan_counter.sv
// Display row counter: advances on en, wraps after ROWS-1.
module tetris_scan_counter #(
  parameter int ROWS = 10,
  parameter int AW   = 4
) (
  input  logic          clk_1,
  input  logic          rst,
  input  logic          en,
  output logic [AW-1:0] row,
  output logic          last
);

  assign last = (row == AW'(ROWS - 1));

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst)
      row <= '0;
    else if (en)
      row <= last ? '0 : row + 1'b1;
  end

endmodule

// File: rtl/game_ram_arbiter.sv
// Shares the game-table RAM between display scan and game controller.
// GAME_PRIO_EN: allow up to MAX_STARVE back-to-back game slots.
module game_ram_arbiter
  import tetris_pkg::*;
#(
  parameter int ROWS       = tetris_pkg::ROWS,
  parameter int COLS       = tetris_pkg::COLS,
  parameter int AW         = tetris_pkg::AW,
  parameter int MAX_STARVE = tetris_pkg::MAX_STARVE
) (
  input  logic            clk_1,
  input  logic            rst,
  output logic [AW-1:0]   ram_addr,
  output logic            ram_we,
  output logic [COLS-1:0] ram_wdata,
  input  logic [COLS-1:0] ram_rdata,
  input  logic            game_req,
  input  logic            game_we,
  input  logic [AW-1:0]   game_addr,
  input  logic [COLS-1:0] game_wdata,
  output logic            game_gnt,
  output logic            game_rvalid,
  output logic [COLS-1:0] game_rdata,
  output logic            game_err,
  output logic [AW-1:0]   disp_addr,
  output logic [COLS-1:0] disp_data,
  output logic            disp_valid,
  output logic            frame_done
);

  localparam logic [AW:0] ROWS_W = (AW + 1)'(ROWS);

  arb_state_e    state;
  arb_state_e    state_nxt;
  logic [AW-1:0] row;
  logic          last;
  logic          in_range;
  logic          rd_oor;
  logic          take;

  assign in_range = ({1'b0, game_addr} < ROWS_W);

  tetris_scan_counter #(
    .ROWS (ROWS),
    .AW   (AW)
  ) u_scan (
    .clk_1 (clk_1),
    .rst   (rst),
    .en    (state == D_CAP),
    .row   (row),
    .last  (last)
  );

`ifdef GAME_PRIO_EN
  localparam int SW = $clog2(MAX_STARVE + 1);
  logic [SW-1:0] starve;

  // starve restarts at D_CAP, so that decision only needs game_req
  assign take = (state == D_CAP) ? game_req :
                (game_req && (starve < SW'(MAX_STARVE)));

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst)
      starve <= '0;
    else if (state == D_CAP)
      starve <= game_req ? SW'(1) : '0;
    else if (take && (state == G_CAP ||
             (state == G_ACC && game_we)))
      starve <= starve + 1'b1;
  end
`else
  assign take = game_req;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  state_nxt = D_RD;
      D_RD:  state_nxt = D_CAP;
      D_CAP: state_nxt = take ? G_ACC : D_RD;
`ifdef GAME_PRIO_EN
      G_ACC: state_nxt = !game_we ? G_CAP :
                         take ? G_ACC : D_RD;
      G_CAP: state_nxt = take ? G_ACC : D_RD;
`else
      G_ACC: state_nxt = game_we ? D_RD : G_CAP;
      G_CAP: state_nxt = D_RD;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  assign game_gnt  = (state == G_ACC);
  assign ram_we    = game_gnt && game_we && in_range;
  assign ram_wdata = game_gnt ? game_wdata : '0;
  assign ram_addr  = (state == D_RD) ? row :
                     game_gnt ? game_addr : '0;

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      disp_valid  <= 1'b0;
      frame_done  <= 1'b0;
      disp_addr   <= '0;
      disp_data   <= '0;
      game_rvalid <= 1'b0;
      game_rdata  <= '0;
      game_err    <= 1'b0;
      rd_oor      <= 1'b0;
    end else begin
      disp_valid  <= 1'b0;
      frame_done  <= 1'b0;
      game_rvalid <= 1'b0;
      game_err    <= 1'b0;
      if (state == D_CAP) begin
        disp_valid <= 1'b1;
        frame_done <= last;
        disp_addr  <= row;
        disp_data  <= ram_rdata;
      end
      if (state == G_ACC) begin
        game_err <= !in_range;
        rd_oor   <= !in_range;
      end
      // out-of-range reads hand back zero, not stale RAM contents
      if (state == G_CAP) begin
        game_rvalid <= 1'b1;
        game_rdata  <= rd_oor ? '0 : ram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_game_ram_arbiter.sv
// Directed bench for game_ram_arbiter with RAM model and scoreboards.
module tb_game_ram_arbiter;

  localparam int ROWS = 10;
  localparam int COLS = 10;
  localparam int AW   = 4;
`ifdef GAME_PRIO_EN
  localparam int EXP_RUN = 3;
`else
  localparam int EXP_RUN = 1;
`endif

  logic            clk_1 = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   ram_addr;
  logic            ram_we;
  logic [COLS-1:0] ram_wdata;
  logic [COLS-1:0] ram_rdata;
  logic            game_req;
  logic            game_we = 1'b0;
  logic [AW-1:0]   game_addr = '0;
  logic [COLS-1:0] game_wdata = '0;
  logic            game_gnt;
  logic            game_rvalid;
  logic [COLS-1:0] game_rdata;
  logic            game_err;
  logic [AW-1:0]   disp_addr;
  logic [COLS-1:0] disp_data;
  logic            disp_valid;
  logic            frame_done;

  logic            req_hold = 1'b0;
  logic            mask_req = 1'b1;
  logic [COLS-1:0] mem [16];
  logic [COLS-1:0] shadow [ROWS];
  logic [COLS-1:0] rd_q [$];
  int              fd_cyc [$];
  int checks = 0, errors = 0, cyc = 0;
  int exp_row = 0, gnt_run = 0, max_run = 0;
  int err_cnt = 0, disp_cnt = 0;
  logic h1 = 1'b0, h2 = 1'b0, e1 = 1'b0;

  always #5 clk_1 = ~clk_1;

  // single-shot requester drops req as soon as it sees its grant
  assign game_req = req_hold && !(mask_req && game_gnt);

  game_ram_arbiter dut (
    .clk_1       (clk_1),
    .rst         (rst),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .game_req    (game_req),
    .game_we     (game_we),
    .game_addr   (game_addr),
    .game_wdata  (game_wdata),
    .game_gnt    (game_gnt),
    .game_rvalid (game_rvalid),
    .game_rdata  (game_rdata),
    .game_err    (game_err),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .frame_done  (frame_done)
  );

  always @(posedge clk_1) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_1) begin
    cyc++;
    if (rst) begin
      chk("reset_ram", {ram_addr, ram_we, ram_wdata, game_gnt}, 64'h0);
      chk("reset_game", {game_rvalid, game_rdata, game_err}, 64'h0);
      chk("reset_disp", {disp_addr, disp_data, disp_valid, frame_done}, 64'h0);
      exp_row = 0; h1 = 0; h2 = 0; e1 = 0; gnt_run = 0;
    end else begin
      chk("frame_done", frame_done, disp_valid && exp_row == ROWS - 1);
      if (frame_done) fd_cyc.push_back(cyc);
      if (disp_valid) begin
        chk("disp_addr", disp_addr, exp_row);
        chk("disp_data", disp_data, shadow[exp_row]);
        exp_row = (exp_row + 1) % ROWS;
        disp_cnt++;
        gnt_run = 0;
      end
      chk("game_rvalid", game_rvalid, h2);
      if (game_rvalid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL rd_q: observed rvalid expected no pending read");
        end else begin
          chk("game_rdata", game_rdata, rd_q.pop_front());
        end
      end
      chk("game_err", game_err, e1);
      if (game_err) err_cnt++;
      if (game_gnt) begin
        chk("gnt_addr", ram_addr, game_addr);
        chk("gnt_we", ram_we, game_we && game_addr < ROWS);
        chk("gnt_wdata", ram_wdata, game_wdata);
        if (game_we && game_addr < ROWS) shadow[game_addr] = game_wdata;
        gnt_run++;
        if (gnt_run > max_run) max_run = gnt_run;
      end else begin
        chk("ram_we_idle", ram_we, 1'b0);
      end
      h2 = h1;
      h1 = game_gnt && !game_we;
      e1 = game_gnt && game_addr >= ROWS;
    end
  end

  task automatic wait_gnt(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_1);
      got = game_gnt;
    end
    chk("gnt_timeout", got, 1'b1);
  endtask

  task automatic game_access(input logic we, input logic [AW-1:0] addr,
                             input logic [COLS-1:0] wd);
    bit got;
    @(posedge clk_1); #1;
    game_we = we; game_addr = addr; game_wdata = wd; req_hold = 1'b1;
    wait_gnt(got);
    if (got && !we) rd_q.push_back(addr < ROWS ? shadow[addr] : '0);
    @(posedge clk_1); #1;
    req_hold = 1'b0;
  endtask

  initial begin
    bit got;
    int d0, e0;
    for (int r = 0; r < 16; r++)
      mem[r] = (r < ROWS) ? COLS'(1) << r : 10'h2AA;
    for (int r = 0; r < ROWS; r++)
      shadow[r] = COLS'(1) << r;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk_1);
    #1 rst = 1'b0;

    // free-running scan
    fd_cyc.delete();
    repeat (50) @(posedge clk_1);
    chk("frame_count", fd_cyc.size() >= 2, 1'b1);
    if (fd_cyc.size() >= 2)
      chk("frame_period", fd_cyc[1] - fd_cyc[0], 20);
    d0 = disp_cnt;
    repeat (20) @(posedge clk_1);
    chk("disp_rate", disp_cnt - d0, 10);

    // write row 3, then watch it in the scan
    game_access(1'b1, 4'd3, 10'h3FF);
    repeat (25) @(posedge clk_1);

    // read row 9 between display slots
    d0 = disp_cnt;
    game_access(1'b0, 4'd9, '0);
    repeat (6) @(posedge clk_1);
    chk("rd_q_drain", rd_q.size(), 0);
    chk("disp_around_read", disp_cnt - d0 >= 2, 1'b1);

    // out-of-range write and read
    e0 = err_cnt;
    game_access(1'b1, 4'd12, 10'h155);
    game_access(1'b0, 4'd12, '0);
    repeat (4) @(posedge clk_1);
    chk("err_pulses", err_cnt - e0, 2);
    chk("rd_q_oor", rd_q.size(), 0);

    // continuous requester
    @(posedge clk_1); #1;
    mask_req = 1'b0; max_run = 0;
    game_we = 1'b1; game_addr = 4'd5; game_wdata = 10'h0AA;
    req_hold = 1'b1;
    d0 = disp_cnt;
    repeat (40) @(posedge clk_1);
    #1 req_hold = 1'b0;
    repeat (4) @(posedge clk_1);
    #1 mask_req = 1'b1;
    chk("max_game_run", max_run, EXP_RUN);
    chk("disp_under_load", disp_cnt - d0 >= 5, 1'b1);
    repeat (25) @(posedge clk_1);

    // reset while a read sits in G_CAP
    @(posedge clk_1); #1;
    game_we = 1'b0; game_addr = 4'd9; req_hold = 1'b1;
    wait_gnt(got);
    @(posedge clk_1); #1;
    rst = 1'b1;
    rd_q.delete();
    repeat (2) @(posedge clk_1);
    #1 rst = 1'b0;
    wait_gnt(got);
    if (got) rd_q.push_back(shadow[9]);
    @(posedge clk_1); #1;
    req_hold = 1'b0;
    repeat (6) @(posedge clk_1);
    chk("regrant_read", rd_q.size(), 0);
    repeat (25) @(posedge clk_1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
